// File: rtl/ins_fetch.sv
// ins_fetch
// Instruction fetch stage for the note-player CPU.
//
// Walks program SRAM one 16-bit word at a time. Each address is held for
// READ_WAIT cycles to cover SRAM access time. The returned word is then
// captured into a small show-ahead prefetch FIFO. The FIFO feeds the execute
// stage through a valid/ready handshake. A redirect from execute flushes the
// FIFO and restarts fetch at the new address.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, the perf_fetched and perf_stalled counters and their ports
//   are added.
//
// Ports:
//   CLK, RST                   clock; synchronous active-high reset
//   SRAM_A      out [ADDR_W]   word address of the current fetch
//   SRAM_D      in  [16]       SRAM read data
//   SRAM_CE/OE/LB/UB  out      tied 0 (active-low, always enabled)
//   SRAM_WE     out            tied 1 (never write)
//   halt        in             block new captures (the wait still counts)
//   redir_valid in             one-cycle redirect request
//   redir_pc    in  [ADDR_W]   redirect target
//   ins_valid   out            FIFO head is valid
//   ins_ready   in             execute accepts the head
//   ins_data    out [16]       head instruction word (0 when empty)
//   ins_pc      out [ADDR_W]   head word address (0 when empty)
//   perf_fetched out [32]      (FETCH_PERF_EN) saturating push count
//   perf_stalled out [32]      (FETCH_PERF_EN) saturating blocked-capture cycles
module ins_fetch #(
    parameter int                ADDR_W     = 18,
    parameter int                READ_WAIT  = 3,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_LB,
    output logic              SRAM_UB,
    output logic              SRAM_WE,
    input  logic              halt,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [15:0]       ins_data,
    output logic [ADDR_W-1:0] ins_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalled
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WCNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    typedef enum logic {
        S_WAIT,
        S_CAPTURE
    } state_e;

    // WAIT covers the first READ_WAIT-1 cycles of an address. CAPTURE is the
    // last of them, so the word is sampled at the end of cycle READ_WAIT-1.
    localparam logic [WCNT_W-1:0] WCNT_LAST =
        WCNT_W'((READ_WAIT >= 2) ? READ_WAIT - 2 : 0);
    // A single-cycle access has no wait phase, so fetch lives in CAPTURE.
    localparam state_e RESTART_STATE = (READ_WAIT == 1) ? S_CAPTURE : S_WAIT;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic [15:0]        data_mem_q [DEPTH];

    logic full;
    logic capture_ok;
    logic push_en;
    logic pop_en;

    assign SRAM_A  = fetch_pc_q;
    assign SRAM_CE = 1'b0;
    assign SRAM_OE = 1'b0;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;
    assign SRAM_WE = 1'b1;

    // Full uses the pre-pop count, so a same-cycle pop never frees a slot
    // for a capture in that cycle.
    assign full       = (count_q == CNT_FULL);
    assign capture_ok = (state_q == S_CAPTURE) && !full && !halt;
    assign push_en    = capture_ok && !redir_valid;
    assign pop_en     = ins_valid && ins_ready && !redir_valid;

    assign ins_valid = (count_q != '0);
    assign ins_data  = ins_valid ? data_mem_q[rd_ptr_q] : '0;
    assign ins_pc    = ins_valid ? pc_mem_q[rd_ptr_q]   : '0;

    // Next-state logic. A redirect overrides everything else in its cycle,
    // including any capture or pop.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wcnt_d     = wcnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redir_valid) begin
            state_d    = RESTART_STATE;
            fetch_pc_d = redir_pc;
            wcnt_d     = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (capture_ok) begin
                        fetch_pc_d = fetch_pc_q + 1'b1;
                        wcnt_d     = '0;
                        state_d    = RESTART_STATE;
                    end
                end
                default: state_d = RESTART_STATE;
            endcase

            if (push_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_d = count_q + 1'b1;
            end else if (!push_en && pop_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RESTART_STATE;
            fetch_pc_q <= START_ADDR;
            wcnt_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wcnt_q     <= wcnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage has no reset. Stale entries are never visible because the
    // outputs are masked by the count.
    always_ff @(posedge CLK) begin
        if (push_en && !RST) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= SRAM_D;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters. A stall is any CAPTURE cycle held back by a full
    // FIFO or by halt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched <= '0;
            perf_stalled <= '0;
        end else begin
            if (push_en && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 1'b1;
            end
            if ((state_q == S_CAPTURE) && (full || halt) && (perf_stalled != '1)) begin
                perf_stalled <= perf_stalled + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch
// Bench for ins_fetch. The SRAM model returns 16'h1000 + address.
// A stimulus process drives directed vectors and makes cycle-exact checks.
// It also queues the hand-computed words that execute should accept.
// A monitor pops that queue every time a word is handed over and compares.
module tb_ins_fetch;

    localparam int ADDR_W = 18;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [15:0]       data;
    } entry_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [ADDR_W-1:0] SRAM_A;
    logic [15:0]       SRAM_D;
    logic              SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_WE;
    logic              halt = 1'b0;
    logic              redir_valid = 1'b0;
    logic [ADDR_W-1:0] redir_pc = '0;
    logic              ins_valid;
    logic              ins_ready = 1'b0;
    logic [15:0]       ins_data;
    logic [ADDR_W-1:0] ins_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stalled;
`endif

    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;
    entry_t expQ[$];
    entry_t monEntry;

    ins_fetch dut (
        .CLK        (CLK),
        .RST        (RST),
        .SRAM_A     (SRAM_A),
        .SRAM_D     (SRAM_D),
        .SRAM_CE    (SRAM_CE),
        .SRAM_OE    (SRAM_OE),
        .SRAM_LB    (SRAM_LB),
        .SRAM_UB    (SRAM_UB),
        .SRAM_WE    (SRAM_WE),
        .halt       (halt),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stalled(perf_stalled)
`endif
    );

    // 100 MHz bench clock; period is irrelevant to the design.
    initial forever #5 CLK = ~CLK;

    // Asynchronous-read SRAM model.
    assign SRAM_D = 16'h1000 + SRAM_A[15:0];

    // Cycle number, where cycle 0 is the first cycle with RST low.
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic applyStimulus(input logic rdy, input logic hlt, input logic rv, input logic [ADDR_W-1:0] rpc);
        ins_ready   = rdy;
        halt        = hlt;
        redir_valid = rv;
        redir_pc    = rpc;
    endtask

    task automatic expectWord(input logic [ADDR_W-1:0] pc, input logic [15:0] d);
        entry_t e;
        e.pc   = pc;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Advance to just after the clock edge that starts the given cycle.
    task automatic atCycle(input int n);
        int guard = 0;
        while (cyc != n) begin
            @(posedge CLK);
            #1;
            guard++;
            if (guard > 500) begin
                $display("[TB] FAIL timeout waiting for cycle %0d", n);
                $fatal(1, "[TB] cycle wait expired");
            end
        end
    endtask

    // Hold reset for a few cycles, then leave the bench at the start of cycle 0.
    task automatic doReset();
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    // Monitor: each accepted head word must be the next queued expectation.
    // A pop in a redirect cycle is dropped by the DUT and is not checked.
    always @(negedge CLK) begin
        if (!RST && ins_valid && ins_ready && !redir_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected word: got pc %h data %h, expected none", ins_pc, ins_data);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("pop pc", 32'(ins_pc), 32'(monEntry.pc));
                checkOutput("pop data", 32'(ins_data), 32'(monEntry.data));
            end
        end
    end

    initial begin
        // Run 1: reset state, then fill the FIFO with ready low. Reset is
        // pulsed in a wait cycle while the FIFO is full.
        doReset();
        @(negedge CLK);
        checkOutput("reset valid", 32'(ins_valid), 32'h0);
        checkOutput("reset SRAM_A", 32'(SRAM_A), 32'h0);
        checkOutput("reset ins_pc", 32'(ins_pc), 32'h0);
        checkOutput("reset ins_data", 32'(ins_data), 32'h0);
        checkOutput("SRAM_WE tie", 32'(SRAM_WE), 32'h1);
        checkOutput("SRAM ctrl ties", 32'({SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB}), 32'h0);
        atCycle(2); @(negedge CLK);
        checkOutput("valid c2", 32'(ins_valid), 32'h0);
        atCycle(3); @(negedge CLK);
        checkOutput("valid c3", 32'(ins_valid), 32'h1);
        checkOutput("head data c3", 32'(ins_data), 32'h1000);
        atCycle(12); @(negedge CLK);
        checkOutput("full valid", 32'(ins_valid), 32'h1);
        checkOutput("full SRAM_A", 32'(SRAM_A), 32'h4);
        checkOutput("full head pc", 32'(ins_pc), 32'h0);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("mid-wait reset valid", 32'(ins_valid), 32'h0);
        checkOutput("mid-wait reset SRAM_A", 32'(SRAM_A), 32'h0);
        checkOutput("mid-wait reset ins_pc", 32'(ins_pc), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Run 2: the first-fetch sequence repeats with ready high.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        expectWord(18'h00000, 16'h1000);
        expectWord(18'h00001, 16'h1001);
        atCycle(2); @(negedge CLK);
        checkOutput("refetch valid c2", 32'(ins_valid), 32'h0);
        atCycle(3); @(negedge CLK);
        checkOutput("refetch valid c3", 32'(ins_valid), 32'h1);
        atCycle(4); @(negedge CLK);
        checkOutput("refetch valid c4", 32'(ins_valid), 32'h0);
        atCycle(6); @(negedge CLK);
        checkOutput("refetch valid c6", 32'(ins_valid), 32'h1);
        checkOutput("refetch pc c6", 32'(ins_pc), 32'h1);
        atCycle(7);

        // Run 3: redirect with a non-empty FIFO and a same-cycle pop, then
        // a redirect to the top of the address space to exercise the wrap.
        doReset();
        atCycle(7);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'h00100);
        atCycle(8);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        expectWord(18'h00100, 16'h1100);
        expectWord(18'h00101, 16'h1101);
        @(negedge CLK);
        checkOutput("redir valid c8", 32'(ins_valid), 32'h0);
        checkOutput("redir SRAM_A c8", 32'(SRAM_A), 32'h00100);
        atCycle(10); @(negedge CLK);
        checkOutput("redir valid c10", 32'(ins_valid), 32'h0);
        atCycle(11); @(negedge CLK);
        checkOutput("redir valid c11", 32'(ins_valid), 32'h1);
        atCycle(15);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'h3FFFF);
        atCycle(16);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        expectWord(18'h3FFFF, 16'h0FFF);
        expectWord(18'h00000, 16'h1000);
        @(negedge CLK);
        checkOutput("wrap SRAM_A c16", 32'(SRAM_A), 32'h3FFFF);
        atCycle(19); @(negedge CLK);
        checkOutput("wrap valid c19", 32'(ins_valid), 32'h1);
        checkOutput("wrap SRAM_A c19", 32'(SRAM_A), 32'h0);
        atCycle(22); @(negedge CLK);
        checkOutput("wrap valid c22", 32'(ins_valid), 32'h1);
        atCycle(23);

        // Run 4: forty cycles with ready low, then drain in order and refill.
        // Halt blocks the next capture but not the buffered word.
        doReset();
        atCycle(39); @(negedge CLK);
        checkOutput("stall valid", 32'(ins_valid), 32'h1);
        checkOutput("stall SRAM_A", 32'(SRAM_A), 32'h4);
        checkOutput("stall head pc", 32'(ins_pc), 32'h0);
        for (int i = 0; i < 5; i++) expectWord(ADDR_W'(i), 16'h1000 + 16'(i));
        atCycle(40);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        atCycle(42); @(negedge CLK);
        checkOutput("refill SRAM_A c42", 32'(SRAM_A), 32'h5);
        atCycle(45);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        @(negedge CLK);
        checkOutput("halt head pc c45", 32'(ins_pc), 32'h5);
        atCycle(50);
        expectWord(18'h00005, 16'h1005);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        atCycle(51); @(negedge CLK);
        checkOutput("halt valid c51", 32'(ins_valid), 32'h0);
        atCycle(56); @(negedge CLK);
        checkOutput("halt SRAM_A c56", 32'(SRAM_A), 32'h6);
        atCycle(57);
        expectWord(18'h00006, 16'h1006);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        atCycle(58); @(negedge CLK);
        checkOutput("unhalt valid c58", 32'(ins_valid), 32'h1);
        atCycle(60);

`ifdef FETCH_PERF_EN
        // Run 5: two fetches, then ten cycles of halt while in CAPTURE.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        expectWord(18'h00000, 16'h1000);
        expectWord(18'h00001, 16'h1001);
        expectWord(18'h00002, 16'h1002);
        atCycle(7); @(negedge CLK);
        checkOutput("perf fetched c7", perf_fetched, 32'd2);
        checkOutput("perf stalled c7", perf_stalled, 32'd0);
        atCycle(8);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        atCycle(18);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        @(negedge CLK);
        checkOutput("perf fetched c18", perf_fetched, 32'd2);
        checkOutput("perf stalled c18", perf_stalled, 32'd10);
        atCycle(20); @(negedge CLK);
        checkOutput("perf fetched c20", perf_fetched, 32'd3);
        atCycle(21);
`endif

        checkOutput("expected words drained", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
